// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: sequences instruction-ROM ownership between CPU fetch and the UART programmer
//   clk, rst        : system clock, async active-high reset
//   upg_btn         : raw upload-request button (debounced here)
//   upg_done        : programmer transfer complete (level)
//   upg_wen/upg_adr : programmer write strobe and word address (MSB = dmem)
//   upg_rst_o       : programmer reset, 1 = programmer idle and CPU owns ROM
//   rom_sel         : 1 = ROM port driven by programmer
//   imem_wen        : imem write strobe, LOAD only
//   dmem_wen        : dmem write strobe, LOAD only
//   cpu_rst         : CPU core reset
//   inited          : program ready
//   word_cnt        : words written in the current or last upload
//   state_o         : current FSM state
module imem_boot_ctrl #(
  parameter int DB_CYCLES  = 1000000,
  parameter int SETTLE_CYC = 16,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upg_btn,
  input  logic              upg_done,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_adr,
  output logic              upg_rst_o,
  output logic              rom_sel,
  output logic              imem_wen,
  output logic              dmem_wen,
  output logic              cpu_rst,
  output logic              inited,
  output logic [15:0]       word_cnt,
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {SETTLE = 2'd0, RUN = 2'd1, LOAD = 2'd2} state_t;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic done_q;
  logic upg_rst_q, upg_rst_d, rom_sel_q, rom_sel_d, cpu_rst_q, cpu_rst_d, inited_q, inited_d;
  logic unused_adr;
  assign unused_adr = ^upg_adr[ADDR_W-2:0];
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    db_cnt_d     = '0;
    word_cnt_d   = word_cnt_q;
    case (state_q)
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
          state_d      = RUN;
          settle_cnt_d = '0;
        end
      end
      RUN: if (upg_btn) begin
        db_cnt_d = db_cnt_q + 1'b1;
        if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
          state_d    = LOAD;
          db_cnt_d   = '0;
          word_cnt_d = '0;
        end
      end
      LOAD: begin
        word_cnt_d = (upg_wen && word_cnt_q != 16'hFFFF) ? word_cnt_q + 16'd1 : word_cnt_q;
        // done_q tracks upg_done every cycle, so a level already high on entry never looks like an edge
        state_d    = (upg_done && !done_q) ? SETTLE : LOAD;
      end
      default: state_d = SETTLE;
    endcase
    // outputs decoded from next state so they switch on the same edge as the state
    upg_rst_d = state_d != LOAD;
    rom_sel_d = state_d == LOAD;
    cpu_rst_d = state_d != RUN;
    inited_d  = state_d == RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      db_cnt_q     <= '0;
      word_cnt_q   <= '0;
      done_q       <= 1'b0;
      upg_rst_q    <= 1'b1;
      rom_sel_q    <= 1'b0;
      cpu_rst_q    <= 1'b1;
      inited_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      db_cnt_q     <= db_cnt_d;
      word_cnt_q   <= word_cnt_d;
      done_q       <= upg_done;
      upg_rst_q    <= upg_rst_d;
      rom_sel_q    <= rom_sel_d;
      cpu_rst_q    <= cpu_rst_d;
      inited_q     <= inited_d;
    end
  end
  assign imem_wen  = (state_q == LOAD) & upg_wen & ~upg_adr[ADDR_W-1];
  assign dmem_wen  = (state_q == LOAD) & upg_wen &  upg_adr[ADDR_W-1];
  assign upg_rst_o = upg_rst_q;
  assign rom_sel   = rom_sel_q;
  assign cpu_rst   = cpu_rst_q;
  assign inited    = inited_q;
  assign word_cnt  = word_cnt_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed table-driven bench for imem_boot_ctrl
module tb_imem_boot_ctrl;
  logic clk = 1'b0, rst = 1'b0, upg_btn = 1'b0, upg_done = 1'b0, upg_wen = 1'b0;
  logic [14:0] upg_adr = '0;
  logic upg_rst_o, rom_sel, imem_wen, dmem_wen, cpu_rst, inited;
  logic [15:0] word_cnt;
  logic [1:0] state_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic btn, wen, done;
    logic [14:0] adr;
    logic [1:0] st;
    logic im, dm;
    logic [15:0] wc;
  } vec_t;
  vec_t tbl[$];
  imem_boot_ctrl #(.DB_CYCLES(8), .SETTLE_CYC(16), .ADDR_W(15)) dut (
    .clk(clk), .rst(rst), .upg_btn(upg_btn), .upg_done(upg_done), .upg_wen(upg_wen),
    .upg_adr(upg_adr), .upg_rst_o(upg_rst_o), .rom_sel(rom_sel), .imem_wen(imem_wen),
    .dmem_wen(dmem_wen), .cpu_rst(cpu_rst), .inited(inited), .word_cnt(word_cnt), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_state(input string tag, input logic [1:0] st, input logic [15:0] wc);
    chk({tag, " state"}, int'(state_o), int'(st));
    chk({tag, " word_cnt"}, int'(word_cnt), int'(wc));
    chk({tag, " cpu_rst"}, int'(cpu_rst), int'(st != 2'd1));
    chk({tag, " inited"}, int'(inited), int'(st == 2'd1));
    chk({tag, " upg_rst_o"}, int'(upg_rst_o), int'(st != 2'd2));
    chk({tag, " rom_sel"}, int'(rom_sel), int'(st == 2'd2));
  endtask
  function automatic void add(input logic btn, wen, done, input logic [14:0] adr,
                              input logic [1:0] st, input logic im, dm, input logic [15:0] wc);
    tbl.push_back('{btn, wen, done, adr, st, im, dm, wc});
  endfunction
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    repeat (7) add(1, 0, 0, 15'h0, 1, 0, 0, 0);
    add(0, 0, 0, 15'h0, 1, 0, 0, 0);
    repeat (7) add(1, 0, 0, 15'h0, 1, 0, 0, 0);
    add(1, 0, 1, 15'h0, 2, 0, 0, 0);
    add(1, 1, 1, 15'h0004, 2, 1, 0, 1);
    add(0, 0, 1, 15'h0, 2, 0, 0, 1);
    add(0, 1, 1, 15'h4000, 2, 0, 1, 2);
    add(0, 1, 1, 15'h0008, 2, 1, 0, 3);
    add(0, 0, 0, 15'h0, 2, 0, 0, 3);
    add(0, 1, 1, 15'h0010, 0, 1, 0, 4);
    repeat (15) add(0, 0, 0, 15'h0, 0, 0, 0, 4);
    add(0, 0, 0, 15'h0, 1, 0, 0, 4);
    add(0, 1, 0, 15'h0004, 1, 0, 0, 4);
    add(0, 1, 0, 15'h4000, 1, 0, 0, 4);
    repeat (7) add(1, 0, 0, 15'h0, 1, 0, 0, 4);
    add(1, 0, 0, 15'h0, 2, 0, 0, 0);
    add(0, 1, 0, 15'h4004, 2, 0, 1, 1);
    add(0, 1, 0, 15'h7ffc, 2, 0, 1, 2);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_state("reset", 2'd0, 16'd0);
    chk("reset imem_wen", int'(imem_wen), 0);
    chk("reset dmem_wen", int'(dmem_wen), 0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("boot cpu_rst", int'(cpu_rst), int'(i < 16));
      chk("boot state", int'(state_o), (i < 16) ? 0 : 1);
    end
    chk("boot inited", int'(inited), 1);
    for (int i = 0; i < tbl.size(); i++) begin
      upg_btn = tbl[i].btn;
      upg_wen = tbl[i].wen;
      upg_done = tbl[i].done;
      upg_adr = tbl[i].adr;
      #1;
      chk($sformatf("v%0d imem_wen", i), int'(imem_wen), int'(tbl[i].im));
      chk($sformatf("v%0d dmem_wen", i), int'(dmem_wen), int'(tbl[i].dm));
      @(negedge clk);
      chk_state($sformatf("v%0d", i), tbl[i].st, tbl[i].wc);
    end
    upg_btn = 1'b0;
    upg_done = 1'b0;
    upg_wen = 1'b1;
    upg_adr = 15'h0004;
    #1;
    chk("preabort imem_wen", int'(imem_wen), 1);
    rst = 1'b1;
    #1;
    chk_state("abort", 2'd0, 16'd0);
    chk("abort imem_wen", int'(imem_wen), 0);
    @(negedge clk);
    rst = 1'b0;
    upg_adr = 15'h4000;
    #1;
    chk("settle dmem_wen", int'(dmem_wen), 0);
    @(negedge clk);
    chk_state("post abort", 2'd0, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
